// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// holds the fetched word for decode. Optional macro MISALIGN_CHECK_EN halts on misaligned taken branches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] ImmOp,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] PC,
    output logic        fetch_timeout,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;

    // Counter holds the number of REQ cycles already spent without ack.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic [31:0]   br_tgt;
    logic [31:0]   seq_pc;

`ifdef MISALIGN_CHECK_EN
    logic err_q, err_d;
`endif

    assign br_tgt = pc_q + ImmOp;
    assign seq_pc = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`ifdef MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = VALID;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            VALID: begin
                if (instr_ready) begin
                    vld_d   = 1'b0;
                    state_d = REQ;
                    if (!PCSrc) begin
                        pc_d = seq_pc;
                    end else begin
`ifdef MISALIGN_CHECK_EN
                        if (br_tgt[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d = br_tgt;
                        end
`else
                        // Misaligned targets are silently forced onto a word boundary.
                        pc_d = br_tgt & ~32'd3;
`endif
                    end
                end
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req      = (state_q == REQ);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = vld_q;
    assign PC            = pc_q;
    assign fetch_timeout = to_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected (PC, instr) pairs,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmOp = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] PC;
    logic        fetch_timeout;
    logic        misalign_err;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmOp(ImmOp),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PC(PC), .fetch_timeout(fetch_timeout),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          to_seen = 0;
    logic [31:0] m_pc = RST_PC;
    bit          after_hs = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Architectural next-PC rule.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic src,
                                            input logic [31:0] imm);
        logic [31:0] t;
        if (!src) return pc + 32'd4;
        t = pc + imm;
        t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_handshake", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pc", PC, e.pc);
                check("sb_instr", instr, e.ins);
            end
        end
        if (!rst && fetch_timeout) to_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int w = 0;
        while (!imem_req && w < 20) begin
            tick();
            w++;
        end
        check("req_wait", {31'd0, imem_req}, 32'd1);
        if (after_hs) check("req_after_handshake", w, 32'd0);
    endtask

    // One full fetch: d ack-wait cycles, s decode stall cycles, then handshake.
    task automatic fetch_one(input int d, input int s, input logic src, input logic [31:0] imm);
        exp_t e;
        e.pc  = m_pc;
        e.ins = mem_word(m_pc);
        sb.push_back(e);
        wait_req();
        check("req_addr", imem_addr, m_pc);
        for (int i = 0; i < d; i++) begin
            tick();
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("req_addr_hold", imem_addr, m_pc);
            check("no_timeout", {31'd0, fetch_timeout}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("valid_rise", {31'd0, instr_valid}, 32'd1);
        check("req_drop", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < s; i++) begin
            imem_ack   = 1'($urandom % 2);
            imem_rdata = $urandom;
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, e.ins);
            check("stall_pc", PC, e.pc);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        PCSrc       = src;
        ImmOp       = imm;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'($urandom % 2);
        ImmOp       = $urandom;
        m_pc        = next_pc(m_pc, src, imm);
        after_hs    = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        m_pc     = RST_PC;
        after_hs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          cnt;
        logic [31:0] imm;

        repeat (3) tick();
        check("rst_pc", PC, RST_PC);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        check("idle_after_rst", {31'd0, imem_req}, 32'd0);
        tick();
        check("req_after_idle", {31'd0, imem_req}, 32'd1);

        // Zero-wait sequential stream 0x0, 0x4, 0x8, 0xC reaching 0x10.
        for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b0, 32'd0);
        check("seq_reach_10", m_pc, 32'h10);
        fetch_one(0, 0, 1'b1, 32'hFFFF_FFF8);
        check("branch_back", m_pc, 32'h08);
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b1, 32'h100);
        check("branch_fwd", m_pc, 32'h110);

        // Delayed ack plus decode stall.
        fetch_one(3, 2, 1'b0, 32'd0);

        // Timeout with no ack, then retry accepted on the last allowed cycle.
        after_hs = 1'b0;
        wait_req();
        a   = imem_addr;
        cnt = 1;
        while (cnt < 20) begin
            tick();
            if (!imem_req) break;
            check("to_addr_hold", imem_addr, a);
            cnt++;
        end
        check("to_req_cycles", cnt, 32'd4);
        check("to_pulse", {31'd0, fetch_timeout}, 32'd1);
        tick();
        check("to_pulse_once", {31'd0, fetch_timeout}, 32'd0);
        check("retry_req", {31'd0, imem_req}, 32'd1);
        check("retry_addr", imem_addr, a);
        fetch_one(3, 0, 1'b0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            imm = (32'($urandom_range(0, 127)) << 2) - 32'd256;
`ifndef MISALIGN_CHECK_EN
            imm = imm | 32'($urandom_range(0, 3));
`endif
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom % 2), imm);
        end

        // Reset wins over an ack in the same cycle.
        fetch_one(0, 0, 1'b1, 32'h40);
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst        = 1'b1;
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        check("rstack_pc", PC, RST_PC);
        check("rstack_instr", instr, 32'd0);
        check("rstack_valid", {31'd0, instr_valid}, 32'd0);
        check("rstack_idle", {31'd0, imem_req}, 32'd0);
        m_pc     = RST_PC;
        after_hs = 1'b0;
        tick();
        check("rstack_req", {31'd0, imem_req}, 32'd1);

        // Misaligned taken branch from 0x20.
        fetch_one(0, 0, 1'b1, 32'h20);
        check("reach_20", m_pc, 32'h20);
`ifdef MISALIGN_CHECK_EN
        fetch_one(0, 0, 1'b1, 32'h6);
        for (int i = 0; i < 6; i++) begin
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_pc", PC, 32'h20);
            check("halt_err", {31'd0, misalign_err}, 32'd1);
            tick();
        end
        apply_reset();
        check("halt_exit_err", {31'd0, misalign_err}, 32'd0);
        after_hs = 1'b0;
        fetch_one(0, 0, 1'b0, 32'd0);
`else
        fetch_one(0, 0, 1'b1, 32'h6);
        check("mask_model", m_pc, 32'h24);
        check("no_misalign", {31'd0, misalign_err}, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
`endif

        tick();
        check("sb_empty", sb.size(), 32'd0);
        check("timeout_count", to_seen, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, holds the fetched instruction for the decode stage, and computes the next PC. The next PC is PC+4 or PC+Imm, using the sign-extended immediate from the immediate generator and the branch decision from control. It sits directly upstream of the immediate generator and control decoder.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT_CYCLES, 15, cycles in REQ without ack before a retry (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- PCSrc  in  1  1 = branch taken (next PC = PC+ImmOp), 0 = sequential
- ImmOp  in  32  sign-extended immediate from the immediate generator
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  held instruction to decode
- instr_valid  out  1  instr is valid
- instr_ready  in  1  decode/execute consumes instr this cycle
- PC  out  32  address of the instruction on instr
- fetch_timeout  out  1  one-cycle pulse when a request is abandoned
- misalign_err  out  1  sticky taken-branch misalignment flag (see Configuration)

## Operation
- States: IDLE, REQ, VALID, HALT.
- Reset values: PC=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_timeout=0, misalign_err=0, timeout counter=0.
- IDLE: imem_req=0. Go to REQ next cycle and clear the timeout counter.
- REQ: imem_req=1 and imem_addr=PC, both held stable until ack or timeout.
  - On imem_ack=1: register imem_rdata into instr, set instr_valid=1, go to VALID.
  - Else increment the counter. When the counter reaches TIMEOUT_CYCLES (no ack), pulse fetch_timeout, go to IDLE, and retry the same PC.
- VALID: imem_req=0 and instr_valid=1, with instr and PC held stable.
  - On instr_ready=1: next PC = PCSrc ? PC+ImmOp : PC+4. Update PC, clear instr_valid, go to REQ.
  - PCSrc and ImmOp are sampled only in that handshake cycle. They are combinational functions of instr and must be valid then.
- HALT: imem_req=0 and instr_valid=0. The only exit is rst.
- Arithmetic: 32-bit unsigned add, wraps modulo 2^32. PC=32'hFFFF_FFFC sequential → 32'h0000_0000.
- imem_ack while imem_req=0 is ignored. imem_rdata is ignored unless ack is seen in REQ.
- imem_ack in the same cycle the counter hits TIMEOUT_CYCLES: the ack wins, with no timeout pulse.

## Timing
- Reset released before edge N: IDLE in cycle N, REQ in cycle N+1.
- Zero-wait memory (ack in the first REQ cycle): instr_valid rises one cycle after the request.
- With instr_ready tied high: one instruction per 2 cycles (REQ, VALID).
- Each cycle of ack delay adds one cycle. Each instr_ready stall adds one cycle.
- Synchronous rst overrides all events in the same cycle, including ack and handshake. The state returns to reset values at that edge, mid-request included.

## Configuration
- MISALIGN_CHECK_EN defined:
  - In a VALID handshake with PCSrc=1 where (PC+ImmOp)[1:0] ≠ 2'b00: PC is not updated, misalign_err goes to 1 (sticky), and the state goes to HALT.
  - Sequential PC+4 is never checked.
- MISALIGN_CHECK_EN undefined:
  - The taken-branch target is loaded as {target[31:2],2'b00}.
  - misalign_err is tied to 0 and HALT is unreachable.

## Test plan
- Reset, zero-wait memory, instr_ready=1, PCSrc=0 → imem_addr sequence 0x0, 0x4, 0x8 on every second cycle; instr_valid pulses one cycle each.
- In VALID at PC=0x10: PCSrc=1, ImmOp=32'hFFFF_FFF8, instr_ready=1 → next imem_addr=0x08. Repeat with ImmOp=0x100 → 0x110.
- Ack delayed 3 cycles and instr_ready low for 2 cycles in VALID → imem_req/imem_addr stable for 4 REQ cycles; instr/PC stable until ready; no timeout pulse.
- TIMEOUT_CYCLES=4, no ack → fetch_timeout pulses once after 4 REQ cycles, one IDLE cycle follows, then REQ re-issues the same address. Also check an ack on the 4th cycle → instruction accepted with no pulse.
- rst asserted in a REQ cycle that also carries imem_ack → next cycle PC=RESET_PC, instr_valid=0, instr=0, state IDLE.
- PC=0x20, PCSrc=1, ImmOp=0x6:
  - With MISALIGN_CHECK_EN: misalign_err=1, PC stays 0x20, imem_req stays 0 until rst.
  - Without it: next imem_addr=0x24 and misalign_err=0.
